// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low glyph table (bit0 = top, bit6 = middle)
// and the decoder's frame-delivery states.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {COLLECT, PRESENT} state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational reverse lookup of an active-low segment pattern into a hex nibble.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b0;
    nibble = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH[i]) begin
        valid  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_decoder.sv
// Samples a multiplexed 7-segment bus, debounces each digit and delivers whole
// decoded words on a valid/ready handshake.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int NDIGITS       = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6:0]             seg_i,
  input  logic [NDIGITS-1:0]     dig_en_i,
  output logic [4*NDIGITS-1:0]   value_o,
  output logic [NDIGITS-1:0]     err_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   overflow_o
);

  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_FIRE = 8'(STABLE_CYCLES - 1);

  logic [6:0]               seg_q, seg_p;
  logic [NDIGITS-1:0]       en_q, en_p;
  logic [7:0]               cnt, cnt_n;
  logic                     same, capture, glyph_ok, complete, load, ovf_n;
  logic [3:0]               nib;
  logic [NDIGITS-1:0]       mask, mask_set;
  logic [NDIGITS-1:0][3:0]  slot_val, slot_val_n, out_val;
  logic [NDIGITS-1:0]       slot_err, slot_err_n;
  state_t                   state, state_n;

  seg7_glyph_decode u_dec (.seg(seg_q), .valid(glyph_ok), .nibble(nib));

  // cnt holds the run length of the previous sample; capture on the one cycle
  // the current sample's run reaches STABLE_CYCLES.
  assign same    = (seg_q == seg_p) && (en_q == en_p);
  assign cnt_n   = !same ? 8'd1 : (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
  assign capture = same && (cnt == CNT_FIRE) && $onehot(en_q);

  always_comb begin
    slot_val_n = slot_val;
    slot_err_n = slot_err;
    mask_set   = mask;
    if (capture) begin
      mask_set = mask | en_q;
      for (int k = 0; k < NDIGITS; k++) begin
        if (en_q[k]) begin
          slot_val_n[k] = nib;
          slot_err_n[k] = !glyph_ok;
        end
      end
    end
  end

  assign complete = capture && (&mask_set);

  always_comb begin
    state_n = state;
    load    = 1'b0;
    ovf_n   = 1'b0;
    case (state)
      COLLECT: if (complete) begin
        load    = 1'b1;
        state_n = PRESENT;
      end
      PRESENT: begin
        if (ready_i) begin
          if (complete) load    = 1'b1;
          else          state_n = COLLECT;
        end else if (complete) begin
          ovf_n = 1'b1;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= '0;
      seg_p      <= '0;
      en_q       <= '0;
      en_p       <= '0;
      cnt        <= '0;
      slot_val   <= '0;
      slot_err   <= '0;
      mask       <= '0;
      state      <= COLLECT;
      out_val    <= '0;
      err_o      <= '0;
      overflow_o <= 1'b0;
    end else begin
      seg_q      <= seg_i;
      en_q       <= dig_en_i;
      seg_p      <= seg_q;
      en_p       <= en_q;
      cnt        <= cnt_n;
      slot_val   <= slot_val_n;
      slot_err   <= slot_err_n;
      mask       <= complete ? '0 : mask_set;
      state      <= state_n;
      overflow_o <= ovf_n;
      if (load) begin
        out_val <= slot_val_n;
        err_o   <= slot_err_n;
      end
    end
  end

  assign value_o = out_val;
  assign valid_o = (state == PRESENT);

endmodule
